// File: rtl/cluster_soc_evt_fifo.sv
// SoC peripheral event buffer in front of the cluster event unit.
// Overflowing events are dropped and counted; status/control is reachable over a peripheral-bus slave plug.
module cluster_soc_evt_fifo #(
    parameter int EVNT_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ID_WIDTH   = 9,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  evt_valid_i,
    input  logic [EVNT_WIDTH-1:0] evt_data_i,

    output logic                  soc_periph_evt_valid_o,
    input  logic                  soc_periph_evt_ready_i,
    output logic [EVNT_WIDTH-1:0] soc_periph_evt_data_o,

    input  logic                  cfg_req_i,
    output logic                  cfg_gnt_o,
    input  logic [31:0]           cfg_add_i,
    input  logic                  cfg_wen_i,
    input  logic [31:0]           cfg_wdata_i,
    input  logic [3:0]            cfg_be_i,
    input  logic [ID_WIDTH-1:0]   cfg_id_i,
    output logic                  cfg_r_valid_o,
    output logic [31:0]           cfg_r_rdata_o,
    output logic                  cfg_r_opc_o,
    output logic [ID_WIDTH-1:0]   cfg_r_id_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [1:0] REG_STATUS    = 2'd0;
    localparam logic [1:0] REG_DROP_CNT  = 2'd1;
    localparam logic [1:0] REG_CTRL      = 2'd2;
    localparam logic [1:0] REG_LAST_DROP = 2'd3;

    localparam logic [31:0] ERR_RDATA = 32'hDEADB33F;

    logic [EVNT_WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]         wr_ptr_reg;
    logic [PW-1:0]         rd_ptr_reg;
    logic                  en_reg;
    logic [CNT_WIDTH-1:0]  drop_cnt_reg;
    logic [EVNT_WIDTH-1:0] last_drop_reg;

    logic                  r_valid_reg;
    logic                  r_opc_reg;
    logic [31:0]           r_rdata_reg;
    logic [ID_WIDTH-1:0]   r_id_reg;

    logic [PW-1:0]         count;
    logic                  full;
    logic                  empty;

    logic                  cfg_err;
    logic [1:0]            reg_sel;
    logic                  cfg_wr;
    logic                  flush;
    logic                  cnt_clr;
    logic                  en_wr;

    logic                  do_pop;
    logic                  do_push;
    logic                  do_drop;
    logic [DEPTH-1:0]      wr_sel;
    logic [31:0]           rd_mux;
    logic [31:0]           r_rdata_next;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    assign count = wr_ptr_reg - rd_ptr_reg;
    assign full  = (count == PW'(DEPTH));
    assign empty = (count == '0);

    assign soc_periph_evt_valid_o = !empty;
    assign soc_periph_evt_data_o  = mem_reg[rd_ptr_reg[AW-1:0]];

    assign cfg_err = |cfg_add_i[11:4];
    assign reg_sel = cfg_add_i[3:2];
    assign cfg_wr  = cfg_req_i && !cfg_wen_i && !cfg_err;
    assign flush   = cfg_wr && (reg_sel == REG_CTRL) && cfg_be_i[0] && cfg_wdata_i[1];
    assign cnt_clr = cfg_wr && (reg_sel == REG_DROP_CNT);
    assign en_wr   = cfg_wr && (reg_sel == REG_CTRL) && cfg_be_i[0];

    // A flush cycle swallows any push, pop or drop happening alongside it.
    assign do_pop  = !empty && soc_periph_evt_ready_i && !flush;
    assign do_push = en_reg && evt_valid_i && (!full || do_pop) && !flush;
    assign do_drop = en_reg && evt_valid_i && full && !do_pop && !flush;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = do_push && (wr_ptr_reg[AW-1:0] == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    mem_reg[i] <= evt_data_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // A clear racing a drop leaves exactly that one drop counted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_reg  <= '0;
            last_drop_reg <= '0;
        end else begin
            if (cnt_clr) begin
                drop_cnt_reg <= do_drop ? CNT_WIDTH'(1) : '0;
            end else if (do_drop && !(&drop_cnt_reg)) begin
                drop_cnt_reg <= drop_cnt_reg + 1'b1;
            end
            if (do_drop) begin
                last_drop_reg <= evt_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_reg <= 1'b1;
        end else if (en_wr) begin
            en_reg <= cfg_wdata_i[0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_STATUS: begin
                rd_mux[31]   = full;
                rd_mux[30]   = empty;
                rd_mux[15:0] = 16'(count);
            end
            REG_DROP_CNT:  rd_mux = 32'(drop_cnt_reg);
            REG_CTRL:      rd_mux = {31'b0, en_reg};
            REG_LAST_DROP: rd_mux = 32'(last_drop_reg);
            default:       rd_mux = '0;
        endcase
    end

    always_comb begin
        r_rdata_next = '0;
        if (cfg_req_i) begin
            if (cfg_err) begin
                r_rdata_next = ERR_RDATA;
            end else if (cfg_wen_i) begin
                r_rdata_next = rd_mux;
            end
        end
    end

    // Grant is immediate, so the response always lands exactly one cycle after the request.
    assign cfg_gnt_o = cfg_req_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_reg <= 1'b0;
            r_opc_reg   <= 1'b0;
            r_rdata_reg <= '0;
            r_id_reg    <= '0;
        end else begin
            r_valid_reg <= cfg_req_i;
            r_opc_reg   <= cfg_req_i && cfg_err;
            r_rdata_reg <= r_rdata_next;
            if (cfg_req_i) begin
                r_id_reg <= cfg_id_i;
            end
        end
    end

    assign cfg_r_valid_o = r_valid_reg;
    assign cfg_r_opc_o   = r_opc_reg;
    assign cfg_r_rdata_o = r_rdata_reg;
    assign cfg_r_id_o    = r_id_reg;

    logic unused_cfg_bits;
    assign unused_cfg_bits = ^{cfg_add_i[31:12], cfg_add_i[1:0], cfg_wdata_i[31:2], cfg_be_i[3:1]};

endmodule

// File: tb/tb_cluster_soc_evt_fifo.sv
// Bench for cluster_soc_evt_fifo: directed scenarios plus randomized traffic against a queue-based model.
module tb_cluster_soc_evt_fifo;

    localparam int EVNT_WIDTH = 8;
    localparam int DEPTH      = 8;
    localparam int ID_WIDTH   = 9;
    localparam int CNT_WIDTH  = 16;
    localparam int CNT_MAX    = (1 << CNT_WIDTH) - 1;

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b0;
    logic                  evt_valid_i = 1'b0;
    logic [EVNT_WIDTH-1:0] evt_data_i = '0;
    logic                  soc_periph_evt_valid_o;
    logic                  soc_periph_evt_ready_i = 1'b0;
    logic [EVNT_WIDTH-1:0] soc_periph_evt_data_o;
    logic                  cfg_req_i = 1'b0;
    logic                  cfg_gnt_o;
    logic [31:0]           cfg_add_i = '0;
    logic                  cfg_wen_i = 1'b1;
    logic [31:0]           cfg_wdata_i = '0;
    logic [3:0]            cfg_be_i = '0;
    logic [ID_WIDTH-1:0]   cfg_id_i = '0;
    logic                  cfg_r_valid_o;
    logic [31:0]           cfg_r_rdata_o;
    logic                  cfg_r_opc_o;
    logic [ID_WIDTH-1:0]   cfg_r_id_o;

    cluster_soc_evt_fifo #(
        .EVNT_WIDTH(EVNT_WIDTH), .DEPTH(DEPTH), .ID_WIDTH(ID_WIDTH), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .evt_valid_i(evt_valid_i), .evt_data_i(evt_data_i),
        .soc_periph_evt_valid_o(soc_periph_evt_valid_o),
        .soc_periph_evt_ready_i(soc_periph_evt_ready_i),
        .soc_periph_evt_data_o(soc_periph_evt_data_o),
        .cfg_req_i(cfg_req_i), .cfg_gnt_o(cfg_gnt_o), .cfg_add_i(cfg_add_i),
        .cfg_wen_i(cfg_wen_i), .cfg_wdata_i(cfg_wdata_i), .cfg_be_i(cfg_be_i),
        .cfg_id_i(cfg_id_i), .cfg_r_valid_o(cfg_r_valid_o), .cfg_r_rdata_o(cfg_r_rdata_o),
        .cfg_r_opc_o(cfg_r_opc_o), .cfg_r_id_o(cfg_r_id_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: event queue plus the architectural registers.
    logic [EVNT_WIDTH-1:0] q [$];
    logic                  en_m = 1'b1;
    int                    cnt_m = 0;
    logic [EVNT_WIDTH-1:0] last_m = '0;
    logic                  exp_rv = 1'b0;
    logic                  exp_opc = 1'b0;
    logic [ID_WIDTH-1:0]   exp_id = '0;
    logic                  exp_rdchk = 1'b0;
    logic [31:0]           exp_rdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_value(input logic [1:0] sel);
        logic [31:0] v;
        v = '0;
        case (sel)
            2'd0: begin
                v[31]   = (q.size() == DEPTH);
                v[30]   = (q.size() == 0);
                v[15:0] = 16'(q.size());
            end
            2'd1: v = 32'(cnt_m);
            2'd2: v = {31'b0, en_m};
            default: v = 32'(last_m);
        endcase
        return v;
    endfunction

    task automatic check_outputs();
        chk("evt_valid", 32'(soc_periph_evt_valid_o), 32'(q.size() != 0));
        if (q.size() != 0) chk("evt_data", 32'(soc_periph_evt_data_o), 32'(q[0]));
        chk("r_valid", 32'(cfg_r_valid_o), 32'(exp_rv));
        if (exp_rv) begin
            chk("r_opc", 32'(cfg_r_opc_o), 32'(exp_opc));
            chk("r_id", 32'(cfg_r_id_o), 32'(exp_id));
            if (exp_rdchk) chk("r_rdata", cfg_r_rdata_o, exp_rdata);
        end
    endtask

    // Called at a falling edge with inputs already applied; advances model and DUT one cycle.
    task automatic tick();
        logic err, wr, flush, clr, en_w, pop, drop;
        int   sz;
        chk("gnt", 32'(cfg_gnt_o), 32'(cfg_req_i));
        err   = (cfg_add_i[11:4] != 8'h00);
        wr    = cfg_req_i && !cfg_wen_i && !err;
        flush = wr && (cfg_add_i[3:2] == 2'd2) && cfg_be_i[0] && cfg_wdata_i[1];
        clr   = wr && (cfg_add_i[3:2] == 2'd1);
        en_w  = wr && (cfg_add_i[3:2] == 2'd2) && cfg_be_i[0];
        exp_rv    = cfg_req_i;
        exp_opc   = cfg_req_i && err;
        exp_id    = cfg_id_i;
        exp_rdchk = cfg_req_i && (err || cfg_wen_i);
        exp_rdata = err ? 32'hDEADB33F : reg_value(cfg_add_i[3:2]);
        sz   = q.size();
        pop  = (sz > 0) && soc_periph_evt_ready_i;
        drop = 1'b0;
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (evt_valid_i && en_m) begin
                if (sz < DEPTH || pop) q.push_back(evt_data_i);
                else begin
                    drop   = 1'b1;
                    last_m = evt_data_i;
                end
            end
        end
        if (clr) cnt_m = drop ? 1 : 0;
        else if (drop && cnt_m < CNT_MAX) cnt_m++;
        if (en_w) en_m = cfg_wdata_i[0];
        @(posedge clk_i);
        @(negedge clk_i);
        check_outputs();
    endtask

    task automatic cfg_read(input logic [31:0] addr, output logic [31:0] data);
        cfg_req_i = 1'b1; cfg_wen_i = 1'b1; cfg_add_i = addr;
        cfg_be_i = 4'hF; cfg_id_i = ID_WIDTH'($urandom);
        tick();
        cfg_req_i = 1'b0;
        data = cfg_r_rdata_o;
    endtask

    task automatic cfg_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        cfg_req_i = 1'b1; cfg_wen_i = 1'b0; cfg_add_i = addr;
        cfg_wdata_i = wdata; cfg_be_i = be; cfg_id_i = ID_WIDTH'($urandom);
        tick();
        cfg_req_i = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        en_m = 1'b1; cnt_m = 0; last_m = '0;
        exp_rv = 1'b0; exp_opc = 1'b0; exp_id = '0; exp_rdchk = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] addr_tab [6];
        logic [EVNT_WIDTH-1:0] drain_exp [DEPTH];

        addr_tab = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h40, 32'h88};

        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst_valid", 32'(soc_periph_evt_valid_o), 32'd0);
        chk("rst_data", 32'(soc_periph_evt_data_o), 32'd0);
        chk("rst_r_valid", 32'(cfg_r_valid_o), 32'd0);
        chk("rst_r_rdata", cfg_r_rdata_o, 32'd0);
        chk("rst_r_id", 32'(cfg_r_id_o), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // 1: single event passes through with one-cycle latency
        evt_valid_i = 1'b1; evt_data_i = 8'h05; soc_periph_evt_ready_i = 1'b1;
        tick();
        evt_valid_i = 1'b0;
        chk("t1_valid", 32'(soc_periph_evt_valid_o), 32'd1);
        chk("t1_data", 32'(soc_periph_evt_data_o), 32'h05);
        tick();
        chk("t1_valid_gone", 32'(soc_periph_evt_valid_o), 32'd0);

        // 2: overflow drops the last two events
        soc_periph_evt_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            evt_valid_i = 1'b1; evt_data_i = 8'(8'h10 + i);
            tick();
        end
        evt_valid_i = 1'b0;
        cfg_read(32'h0, rd);
        chk("t2_count", 32'(rd[15:0]), 32'd8);
        chk("t2_full", 32'(rd[31]), 32'd1);
        cfg_read(32'h4, rd);
        chk("t2_drop_cnt", rd, 32'd2);
        cfg_read(32'hC, rd);
        chk("t2_last_drop", rd, 32'h19);

        // 3: full FIFO with simultaneous pop and push accepts the push
        soc_periph_evt_ready_i = 1'b1; evt_valid_i = 1'b1; evt_data_i = 8'h20;
        tick();
        soc_periph_evt_ready_i = 1'b0; evt_valid_i = 1'b0;
        cfg_read(32'h0, rd);
        chk("t3_count", 32'(rd[15:0]), 32'd8);
        cfg_read(32'h4, rd);
        chk("t3_drop_cnt", rd, 32'd2);
        for (int i = 0; i < DEPTH - 1; i++) drain_exp[i] = 8'(8'h11 + i);
        drain_exp[DEPTH-1] = 8'h20;
        soc_periph_evt_ready_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("t3_drain", 32'(soc_periph_evt_data_o), 32'(drain_exp[i]));
            tick();
        end
        soc_periph_evt_ready_i = 1'b0;

        // 4: disabled input discards without counting
        cfg_write(32'h8, 32'h0, 4'h1);
        for (int i = 0; i < 3; i++) begin
            evt_valid_i = 1'b1; evt_data_i = 8'(8'h30 + i);
            tick();
        end
        evt_valid_i = 1'b0;
        cfg_read(32'h0, rd);
        chk("t4_count_dis", 32'(rd[15:0]), 32'd0);
        cfg_read(32'h4, rd);
        chk("t4_drop_dis", rd, 32'd2);
        cfg_write(32'h8, 32'h1, 4'h1);
        evt_valid_i = 1'b1; evt_data_i = 8'h40;
        tick();
        evt_valid_i = 1'b0;
        cfg_read(32'h0, rd);
        chk("t4_count_en", 32'(rd[15:0]), 32'd1);

        // 5: flush empties the queue, EN keeps the written value
        for (int i = 0; i < 3; i++) begin
            evt_valid_i = 1'b1; evt_data_i = 8'(8'h50 + i);
            tick();
        end
        evt_valid_i = 1'b0;
        cfg_write(32'h8, 32'h3, 4'hF);
        chk("t5_valid", 32'(soc_periph_evt_valid_o), 32'd0);
        cfg_read(32'h0, rd);
        chk("t5_empty", 32'(rd[30]), 32'd1);
        cfg_read(32'h8, rd);
        chk("t5_ctrl", rd, 32'd1);

        // 6: drop counter saturation, clear racing a drop, out-of-range access
        for (int i = 0; i < DEPTH; i++) begin
            evt_valid_i = 1'b1; evt_data_i = 8'(i);
            tick();
        end
        evt_data_i = 8'hA5;
        for (int i = 0; i < CNT_MAX + 4; i++) tick();
        evt_valid_i = 1'b0;
        cfg_read(32'h4, rd);
        chk("t6_drop_sat", rd, 32'h0000FFFF);
        evt_valid_i = 1'b1; evt_data_i = 8'h77;
        cfg_write(32'h4, 32'h0, 4'h0);
        evt_valid_i = 1'b0;
        cfg_read(32'h4, rd);
        chk("t6_clr_race", rd, 32'd1);
        cfg_req_i = 1'b1; cfg_wen_i = 1'b1; cfg_add_i = 32'h40; cfg_id_i = 9'h1A5;
        tick();
        cfg_req_i = 1'b0;
        chk("t6_err_opc", 32'(cfg_r_opc_o), 32'd1);
        chk("t6_err_rdata", cfg_r_rdata_o, 32'hDEADB33F);
        chk("t6_err_id", 32'(cfg_r_id_o), 32'h1A5);
        cfg_write(32'h48, 32'h2, 4'hF);
        cfg_read(32'h0, rd);
        chk("t6_err_nowrite", 32'(rd[15:0]), 32'd8);

        // Reset in the middle of a request: no response, state back to reset
        cfg_req_i = 1'b1; cfg_wen_i = 1'b1; cfg_add_i = 32'h4;
        #2 rst_ni = 1'b0;
        #1;
        chk("mr_valid", 32'(soc_periph_evt_valid_o), 32'd0);
        @(negedge clk_i);
        cfg_req_i = 1'b0;
        chk("mr_r_valid", 32'(cfg_r_valid_o), 32'd0);
        rst_ni = 1'b1;
        model_reset();
        cfg_read(32'h4, rd);
        chk("mr_drop_cnt", rd, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            evt_valid_i = ($urandom_range(0, 3) != 0);
            evt_data_i  = EVNT_WIDTH'($urandom);
            soc_periph_evt_ready_i = (i % 400 < 200) ? ($urandom_range(0, 2) == 0)
                                                     : ($urandom_range(0, 2) != 0);
            cfg_req_i   = ($urandom_range(0, 4) == 0);
            cfg_wen_i   = 1'($urandom_range(0, 1));
            cfg_add_i   = addr_tab[$urandom_range(0, 5)];
            cfg_wdata_i = $urandom;
            if ($urandom_range(0, 4) != 0) cfg_wdata_i[0] = 1'b1;
            if ($urandom_range(0, 3) != 0) cfg_wdata_i[1] = 1'b0;
            cfg_be_i    = 4'($urandom);
            cfg_id_i    = ID_WIDTH'($urandom);
            tick();
        end
        cfg_req_i = 1'b0; evt_valid_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
